// File: rtl/dtc_vote_accumulator.sv
// dtc_vote_accumulator: windowed majority vote over per-sample 2-bit class predictions.
// Counts one vote per accepted sample. When a window closes (WINDOW samples or an
// early flush) it runs a 4-cycle argmax and presents the winner over valid/ready.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   in_valid/in_ready/in_class prediction input handshake
//   flush                      close the current window early (sampled while in_ready=1)
//   out_valid/out_ready        result handshake
//   out_class/out_count        winning class and its vote count
//   out_total/out_tie          samples in the window, tie flag
//   busy                       window in progress or result pending
`timescale 1ns/1ps
module dtc_vote_accumulator #(
    parameter int unsigned WINDOW = 16,
    parameter int unsigned CNT_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_class,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_class,
    output logic [CNT_W-1:0] out_count,
    output logic [CNT_W-1:0] out_total,
    output logic             out_tie,
    output logic             busy
);

    localparam logic [1:0] ST_ACCUM = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_EMIT  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [CNT_W-1:0] total_q, total_d;
    logic [1:0]       k_q, k_d;
    logic [1:0]       best_q, best_d;
    logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
    logic             tie_q, tie_d;
    logic             out_valid_q, out_valid_d;
    logic [1:0]       out_class_q, out_class_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic [CNT_W-1:0] out_total_q, out_total_d;
    logic             out_tie_q, out_tie_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;

    logic             accept;
    logic [CNT_W-1:0] post_total;
    logic [1:0]       cand_best;
    logic [CNT_W-1:0] cand_cnt;
    logic             cand_tie;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
            total_q     <= '0;
            k_q         <= '0;
            best_q      <= '0;
            best_cnt_q  <= '0;
            tie_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_class_q <= '0;
            out_count_q <= '0;
            out_total_q <= '0;
            out_tie_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
            total_q     <= total_d;
            k_q         <= k_d;
            best_q      <= best_d;
            best_cnt_q  <= best_cnt_d;
            tie_q       <= tie_d;
            out_valid_q <= out_valid_d;
            out_class_q <= out_class_d;
            out_count_q <= out_count_d;
            out_total_q <= out_total_d;
            out_tie_q   <= out_tie_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        for (int i = 0; i < 4; i++) cnt_d[i] = cnt_q[i];
        total_d     = total_q;
        k_d         = k_q;
        best_d      = best_q;
        best_cnt_d  = best_cnt_q;
        tie_d       = tie_q;
        out_valid_d = out_valid_q;
        out_class_d = out_class_q;
        out_count_d = out_count_q;
        out_total_d = out_total_q;
        out_tie_d   = out_tie_q;
        cand_best   = best_q;
        cand_cnt    = best_cnt_q;
        cand_tie    = tie_q;

        // in_ready is high exactly in ACCUM, so the state decode stands in for it
        accept     = in_valid && (state_q == ST_ACCUM);
        post_total = total_q + CNT_W'(accept);

        case (state_q)
            ST_ACCUM: begin
                if (accept) begin
                    cnt_d[in_class] = cnt_q[in_class] + CNT_W'(1);
                    total_d         = post_total;
                end
                if ((accept && post_total == CNT_W'(WINDOW)) ||
                    (flush && post_total != '0)) begin
                    state_d = ST_SCAN;
                    k_d     = 2'd0;
                end
            end
            ST_SCAN: begin
                // strict > keeps the lowest index on equal counts
                if (k_q == 2'd0) begin
                    cand_best = 2'd0;
                    cand_cnt  = cnt_q[0];
                    cand_tie  = 1'b0;
                end else if (cnt_q[k_q] > best_cnt_q) begin
                    cand_best = k_q;
                    cand_cnt  = cnt_q[k_q];
                    cand_tie  = 1'b0;
                end else if (cnt_q[k_q] == best_cnt_q) begin
                    cand_tie  = 1'b1;
                end
                best_d     = cand_best;
                best_cnt_d = cand_cnt;
                tie_d      = cand_tie;
                k_d        = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    state_d     = ST_EMIT;
                    out_valid_d = 1'b1;
                    out_class_d = cand_best;
                    out_count_d = cand_cnt;
                    out_total_d = total_q;
                    out_tie_d   = cand_tie;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    for (int i = 0; i < 4; i++) cnt_d[i] = '0;
                    total_d     = '0;
                    out_valid_d = 1'b0;
                    state_d     = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase

        in_ready_d = (state_d == ST_ACCUM);
        busy_d     = (total_d != '0) || (state_d != ST_ACCUM);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_class = out_class_q;
    assign out_count = out_count_q;
    assign out_total = out_total_q;
    assign out_tie   = out_tie_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dtc_vote_accumulator.sv
`timescale 1ns/1ps
module tb_dtc_vote_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_class;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_class;
    logic [4:0] out_count;
    logic [4:0] out_total;
    logic       out_tie;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    dtc_vote_accumulator #(.WINDOW(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
        .out_count(out_count), .out_total(out_total), .out_tie(out_tie), .busy(busy)
    );

    always #5 clk = ~clk;

    // drive one sample for one cycle (inputs change on negedge, DUT samples on posedge)
    task automatic send(input logic [1:0] cls, input logic fl);
        in_valid = 1'b1;
        in_class = cls;
        flush    = fl;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_class = 2'd0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0d exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%0d exp=1", in_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0d exp=0", busy); end
        checks++; if ({out_class, out_count, out_total, out_tie} !== 13'd0) begin failures++;
            $display("FAIL rst_outputs got=%0d/%0d/%0d/%0d exp=0/0/0/0", out_class, out_count, out_total, out_tie); end
    endtask

    task automatic test_full_window();
        logic [1:0] seq [16] = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd0, 2'd1, 2'd3, 2'd1,
                                 2'd2, 2'd1, 2'd1, 2'd0, 2'd1, 2'd2, 2'd1, 2'd1};
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(seq[i], 1'b0);
        // now in cycle T+1
        for (int c = 1; c <= 4; c++) begin
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin failures++;
                $display("FAIL full_scan_cycle%0d got valid=%0d ready=%0d exp valid=0 ready=0", c, out_valid, in_ready); end
            @(negedge clk);
        end
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++;
            $display("FAIL full_t5 got valid=%0d ready=%0d exp valid=1 ready=0", out_valid, in_ready); end
        checks++; if (out_class !== 2'd1 || out_count !== 5'd10 || out_total !== 5'd16 || out_tie !== 1'b0) begin failures++;
            $display("FAIL full_result got=%0d/%0d/%0d/%0d exp=1/10/16/0", out_class, out_count, out_total, out_tie); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin failures++;
            $display("FAIL full_t6 got valid=%0d ready=%0d busy=%0d exp 0/1/0", out_valid, in_ready, busy); end
    endtask

    task automatic test_tie();
        bit ok;
        for (int i = 0; i < 8; i++) send(2'd3, 1'b0);
        for (int i = 0; i < 8; i++) send(2'd2, 1'b0);
        wait_out(ok);
        checks++; if (!ok) begin failures++; $display("FAIL tie_timeout got=no_valid exp=valid"); end
        checks++; if (out_class !== 2'd2 || out_count !== 5'd8 || out_total !== 5'd16 || out_tie !== 1'b1) begin failures++;
            $display("FAIL tie_result got=%0d/%0d/%0d/%0d exp=2/8/16/1", out_class, out_count, out_total, out_tie); end
        @(negedge clk);
    endtask

    task automatic test_flush();
        bit ok;
        bit seen;
        send(2'd0, 1'b0); send(2'd3, 1'b0); send(2'd3, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_out(ok);
        checks++; if (!ok) begin failures++; $display("FAIL flush_timeout got=no_valid exp=valid"); end
        checks++; if (out_class !== 2'd3 || out_count !== 5'd2 || out_total !== 5'd3 || out_tie !== 1'b0) begin failures++;
            $display("FAIL flush_result got=%0d/%0d/%0d/%0d exp=3/2/3/0", out_class, out_count, out_total, out_tie); end
        @(negedge clk);
        // flush on an empty window must be ignored
        flush = 1'b1;
        repeat (2) @(negedge clk);
        flush = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen) begin failures++; $display("FAIL flush_empty got=activity exp=idle"); end
    endtask

    task automatic test_flush_with_accept();
        bit ok;
        send(2'd0, 1'b0); send(2'd1, 1'b0); send(2'd0, 1'b0); send(2'd0, 1'b1);
        wait_out(ok);
        checks++; if (!ok) begin failures++; $display("FAIL flacc_timeout got=no_valid exp=valid"); end
        checks++; if (out_class !== 2'd0 || out_count !== 5'd3 || out_total !== 5'd4 || out_tie !== 1'b0) begin failures++;
            $display("FAIL flacc_result got=%0d/%0d/%0d/%0d exp=0/3/4/0", out_class, out_count, out_total, out_tie); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        bit ok;
        bit bad;
        out_ready = 1'b0;
        send(2'd2, 1'b0); send(2'd2, 1'b0); send(2'd1, 1'b1);
        wait_out(ok);
        checks++; if (!ok) begin failures++; $display("FAIL bp_timeout got=no_valid exp=valid"); end
        in_valid = 1'b1; in_class = 2'd0;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_class !== 2'd2 || out_count !== 5'd2 ||
                out_total !== 5'd3 || out_tie !== 1'b0 || busy !== 1'b1) bad = 1'b1;
            @(negedge clk);
        end
        checks++; if (bad) begin failures++;
            $display("FAIL bp_hold got=%0d/%0d/%0d/%0d ready=%0d exp=2/2/3/0 ready=0", out_class, out_count, out_total, out_tie, in_ready); end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin failures++;
            $display("FAIL bp_release got valid=%0d ready=%0d busy=%0d exp 0/1/0", out_valid, in_ready, busy); end
        checks++; if (out_class !== 2'd2 || out_count !== 5'd2 || out_total !== 5'd3) begin failures++;
            $display("FAIL bp_outputs_held got=%0d/%0d/%0d exp=2/2/3", out_class, out_count, out_total); end
        send(2'd3, 1'b1);
        wait_out(ok);
        checks++; if (!ok || out_class !== 2'd3 || out_count !== 5'd1 || out_total !== 5'd1) begin failures++;
            $display("FAIL bp_next_window got=%0d/%0d/%0d exp=3/1/1", out_class, out_count, out_total); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        bit ok;
        bit seen;
        for (int i = 0; i < 7; i++) send(2'd1, 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin failures++;
            $display("FAIL arst_window got valid=%0d ready=%0d busy=%0d exp 0/1/0", out_valid, in_ready, busy); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 9; i++) send(2'd0, 1'b0);
        for (int i = 0; i < 7; i++) send(2'd3, 1'b0);
        wait_out(ok);
        checks++; if (!ok || out_class !== 2'd0 || out_count !== 5'd9 || out_total !== 5'd16 || out_tie !== 1'b0) begin failures++;
            $display("FAIL arst_fresh got=%0d/%0d/%0d/%0d exp=0/9/16/0", out_class, out_count, out_total, out_tie); end
        @(negedge clk);
        // reset during SCAN
        send(2'd1, 1'b0); send(2'd1, 1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin failures++;
            $display("FAIL arst_scan got valid=%0d ready=%0d busy=%0d exp 0/1/0", out_valid, in_ready, busy); end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen) begin failures++; $display("FAIL arst_scan_no_emit got=valid exp=none"); end
        for (int i = 0; i < 16; i++) send(2'd2, 1'b0);
        wait_out(ok);
        checks++; if (!ok || out_class !== 2'd2 || out_count !== 5'd16 || out_total !== 5'd16 || out_tie !== 1'b0) begin failures++;
            $display("FAIL arst_scan_fresh got=%0d/%0d/%0d/%0d exp=2/16/16/0", out_class, out_count, out_total, out_tie); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_full_window();
        test_tie();
        test_flush();
        test_flush_with_accept();
        test_backpressure();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
